// File: rtl/rd_burst_scheduler.sv
// Round-robin owner of the channel word buffer's single read port: grants one
// channel at a time and sequences a burst of WORDS fixed-length read slots.
module rd_burst_scheduler #(
  parameter int N_CH   = 5,
  parameter int WORDS  = 18,
  parameter int AW     = 5,
  parameter int SLOT   = 64,
  parameter int RD_ON  = 40,
  parameter int RD_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic            busy,
  output logic [AW-1:0]   rd_adr,
  output logic            adr_valid,
  output logic [N_CH-1:0] rd,
  output logic [N_CH-1:0] done
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(SLOT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT,
    ST_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] rd_q, rd_d;
  logic [N_CH-1:0] done_q, done_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [N_CH-1:0] armed_q, armed_d;
  logic [N_CH-1:0] sync1_q, sreq_q;

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] sel_mask;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   idx;
  logic            found;
  logic            take;

  // Search upward from the channel after the last owner, wrapping at N_CH.
  // NOTE: every always_comb output is given a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pending = sreq_q & armed_q;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = PW'((int'(rr_q) + i) % N_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_mask = N_CH'(1) << sel;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rd_d    = '0;
    done_d  = '0;
    take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          take    = 1'b1;
          grant_d = sel_mask;
          rr_d    = sel;
          busy_d  = 1'b1;
          word_d  = '0;
          cnt_d   = '0;
          state_d = ST_SLOT;
        end
      end
      ST_SLOT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= CW'(RD_ON) && cnt_q <= CW'(RD_ON + RD_LEN - 1)) begin
          rd_d = grant_q;
        end
        if (cnt_q == CW'(SLOT - 1)) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (word_q == AW'(WORDS - 1)) begin
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
          word_d  = '0;
          state_d = ST_IDLE;
        end else begin
          word_d  = word_q + AW'(1);
          state_d = ST_SLOT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A channel re-arms only after its synchronised strobe has been seen low.
    armed_d = armed_q | ~sreq_q;
    if (take) begin
      armed_d = armed_d & ~sel_mask;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      done_q  <= '0;
      rr_q    <= PW'(N_CH - 1);
      armed_q <= '1;
      sync1_q <= '0;
      sreq_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      armed_q <= armed_d;
      sync1_q <= req;
      sreq_q  <= sync1_q;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign adr_valid = busy_q;
  assign rd_adr    = busy_q ? word_q : '0;
  assign rd        = rd_q;
  assign done      = done_q;

endmodule
